// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared IEEE-754 single-precision field widths, special
//               constants and the sequential subtractor state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX    = 8'hFF;
    localparam logic [31:0]      FP_NAN_OUT = 32'h7FFF_FFFF;
    localparam logic [31:0]      FP_ZERO    = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        PACK  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_unpack_swap.sv
`default_nettype none
// ============================================================================
// Module      : fp_unpack_swap
// Description : Combinational front end of the subtractor: negates b,
//               unpacks both operands, orders them by magnitude, saturates
//               the alignment distance and resolves the special cases.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_unpack_swap
    import fp_pkg::*;
#(
    parameter int ALIGN_CAP = 23   // must fit in 5 bits
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        s1,
    output logic [7:0]  e1,
    output logic [23:0] m1,
    output logic [23:0] m2,
    output logic [4:0]  d,
    output logic        op_sub,
    output logic        special,
    output logic [31:0] special_out
);

    localparam logic [7:0] CAP_W8 = 8'(ALIGN_CAP);

    logic [31:0] w_bn;
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic        w_swap;
    logic [7:0]  w_e2;
    logic [7:0]  w_ediff;
    logic        w_nan;

    // Subtraction is addition of the sign-flipped subtrahend.
    assign w_bn = {~b[31], b[30:0]};
    assign w_ea = a[30:23];
    assign w_eb = w_bn[30:23];
    assign w_ma = {1'b1, a[22:0]};
    assign w_mb = {1'b1, w_bn[22:0]};

    // Operand ordering so that X1 always carries the larger magnitude.
    always_comb begin
        w_swap = (w_eb > w_ea) || ((w_eb == w_ea) && (w_mb > w_ma));
        s1     = w_swap ? w_bn[31] : a[31];
        e1     = w_swap ? w_eb : w_ea;
        w_e2   = w_swap ? w_ea : w_eb;
        m1     = w_swap ? w_mb : w_ma;
        m2     = w_swap ? w_ma : w_mb;
        w_ediff = e1 - w_e2;
        d      = (w_ediff > CAP_W8) ? CAP_W8[4:0] : w_ediff[4:0];
        op_sub = a[31] ^ w_bn[31];
    end

    // Special-case detection with NaN/Inf inputs taking priority over zeros.
    always_comb begin
        w_nan       = (w_ea == EXP_MAX) || (w_eb == EXP_MAX);
        special     = 1'b1;
        special_out = FP_ZERO;
        if (w_nan) begin
            special_out = FP_NAN_OUT;
        end else if (a[30:0] == 31'd0) begin
            special_out = w_bn;
        end else if (b[30:0] == 31'd0) begin
            special_out = a;
        end else begin
            special = 1'b0;
        end
    end

endmodule : fp_unpack_swap
`default_nettype wire

// File: rtl/fp_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_subtractor_seq
// Description : Multi-cycle single-precision subtractor (out = a - b).
//               Alignment and normalisation shift one bit per clock.
//               Valid/ready handshake on both input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_subtractor_seq
    import fp_pkg::*;
#(
    parameter int ALIGN_CAP = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    state_t r_state;
    state_t w_state_nxt;

    logic        r_s3;
    logic [7:0]  r_e1;
    logic [23:0] r_m1;
    logic [23:0] r_m2;
    logic        r_op_sub;
    logic [4:0]  r_cnt;
    logic [24:0] r_m3;
    logic [4:0]  r_lz;
    logic [31:0] r_out;

    logic        w_s1;
    logic [7:0]  w_e1;
    logic [23:0] w_m1;
    logic [23:0] w_m2;
    logic [4:0]  w_d;
    logic        w_op_sub;
    logic        w_special;
    logic [31:0] w_special_out;

    logic              w_norm_done;
    logic signed [9:0] w_exp_calc;
    logic [31:0]       w_pack_out;

    fp_unpack_swap #(
        .ALIGN_CAP (ALIGN_CAP)
    ) u_unpack_swap (
        .a           (a),
        .b           (b),
        .s1          (w_s1),
        .e1          (w_e1),
        .m1          (w_m1),
        .m2          (w_m2),
        .d           (w_d),
        .op_sub      (w_op_sub),
        .special     (w_special),
        .special_out (w_special_out)
    );

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out         = r_out;
    assign w_norm_done = r_m3[24] || (r_m3 == 25'd0);

    // Biased exponent after normalisation; signed so underflow is visible.
    assign w_exp_calc = $signed({2'b00, r_e1}) + 10'sd1 - $signed({5'b00000, r_lz});

    // Result packing: zero, flush-to-zero, overflow to infinity, or truncated normal.
    always_comb begin
        w_pack_out = FP_ZERO;
        if (r_m3 != 25'd0) begin
            if (w_exp_calc <= 10'sd0) begin
                w_pack_out = FP_ZERO;
            end else if (w_exp_calc >= 10'sd255) begin
                w_pack_out = {r_s3, EXP_MAX, 23'h0};
            end else begin
                w_pack_out = {r_s3, w_exp_calc[7:0], r_m3[23:1]};
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; special operands skip straight to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_special) begin
                        w_state_nxt = DONE;
                    end else if (w_d != 5'd0) begin
                        w_state_nxt = ALIGN;
                    end else begin
                        w_state_nxt = ADD;
                    end
                end
            end
            ALIGN:   if (r_cnt == 5'd1) w_state_nxt = ADD;
            ADD:     w_state_nxt = NORM;
            NORM:    if (w_norm_done) w_state_nxt = PACK;
            PACK:    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath registers: capture, bit-serial align, add, bit-serial normalise, pack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3     <= 1'b0;
            r_e1     <= 8'd0;
            r_m1     <= 24'd0;
            r_m2     <= 24'd0;
            r_op_sub <= 1'b0;
            r_cnt    <= 5'd0;
            r_m3     <= 25'd0;
            r_lz     <= 5'd0;
            r_out    <= FP_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s3     <= w_s1;
                        r_e1     <= w_e1;
                        r_m1     <= w_m1;
                        r_m2     <= w_m2;
                        r_op_sub <= w_op_sub;
                        r_cnt    <= w_d;
                        r_m3     <= 25'd0;
                        r_lz     <= 5'd0;
                        if (w_special) begin
                            r_out <= w_special_out;
                        end
                    end
                end
                ALIGN: begin
                    r_m2  <= r_m2 >> 1;
                    r_cnt <= r_cnt - 5'd1;
                end
                ADD: begin
                    r_m3 <= r_op_sub ? ({1'b0, r_m1} - {1'b0, r_m2})
                                     : ({1'b0, r_m1} + {1'b0, r_m2});
                end
                NORM: begin
                    if (!w_norm_done) begin
                        r_m3 <= r_m3 << 1;
                        r_lz <= r_lz + 5'd1;
                    end
                end
                PACK: begin
                    r_out <= w_pack_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : fp_subtractor_seq
`default_nettype wire
